// File: rtl/quire_window_arbiter_pkg.sv
// quire_window_arbiter_pkg
//   Shared types and width helpers for the quire window arbiter.
//   - arb_state_t         : arbiter FSM states
//   - get_fraction_width  : fraction bus width of a decoded posit (or product)
//   - get_scale_width     : signed scale bus width of a decoded posit (or product)
//   - get_owner_width     : owner-ID width, clog2 of requester count, minimum 1
package quire_window_arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  // Significand width including the hidden bit.
  // A product of two significands is twice as wide.
  function automatic int get_fraction_width(int posit_width, int posit_es, int is_prod);
    int sig_w;
    sig_w = posit_width - posit_es - 2;
    if (sig_w < 1) sig_w = 1;
    return (is_prod != 0) ? 2 * sig_w : sig_w;
  endfunction

  // Regime magnitude needs clog2(n-1) bits, plus es exponent bits and a sign bit.
  // A product adds one more bit of scale range.
  function automatic int get_scale_width(int posit_width, int posit_es, int is_prod);
    int w;
    w = $clog2(posit_width - 1) + posit_es + 1;
    return (is_prod != 0) ? w + 1 : w;
  endfunction

  function automatic int get_owner_width(int nb_req);
    return (nb_req <= 2) ? 1 : $clog2(nb_req);
  endfunction

endpackage

// File: rtl/quire_window_arbiter_tag_fifo.sv
// quire_window_arbiter_tag_fifo
//   Small synchronous FIFO holding the owner tag of each window sent to the quire.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     push, push_data   : write request and tag
//     pop               : read request (ignored while empty)
//     head              : tag at the FIFO head (undefined while empty)
//     full, empty       : occupancy flags
//   A push while full is accepted only together with a pop.
module quire_window_arbiter_tag_fifo
  import quire_window_arbiter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/quire_window_arbiter.sv
// quire_window_arbiter
//   Round-robin arbiter sharing one quire among NB_REQ product streams, one
//   sow..eow window at a time, and tracking which requester owns each result.
//   Ports:
//     clk, rst                     : clock, asynchronous active-high reset
//     req_rts_i / req_rtr_o        : per-requester handshake
//     req_{sow,eow,sign,zero,NaR}_i: per-requester beat flags
//     req_fraction_i, req_scale_i  : packed per-requester data, k at [k*W +: W]
//     q_rts_o / q_rtr_i, q_*_o     : granted beat towards the quire
//     qo_rts_i, qo_rtr_i, qo_eow_i : snooped quire result handshake
//     owner_o, owner_valid_o       : owner tag of the result at the quire output
//     err_len_o, err_tag_o         : sticky window-length / tag-underflow errors
module quire_window_arbiter
  import quire_window_arbiter_pkg::*;
#(
  parameter int POSIT_WIDTH   = 8,
  parameter int POSIT_ES      = 0,
  parameter int IS_PROD_ACCUM = 1,
  parameter int LOG_NB_ACCUM  = 15,
  parameter int NB_REQ        = 4,
  parameter int TAG_DEPTH     = 4,
  localparam int FW = get_fraction_width(POSIT_WIDTH, POSIT_ES, IS_PROD_ACCUM),
  localparam int SW = get_scale_width(POSIT_WIDTH, POSIT_ES, IS_PROD_ACCUM),
  localparam int OW = get_owner_width(NB_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NB_REQ-1:0]    req_rts_i,
  output logic [NB_REQ-1:0]    req_rtr_o,
  input  logic [NB_REQ-1:0]    req_sow_i,
  input  logic [NB_REQ-1:0]    req_eow_i,
  input  logic [NB_REQ-1:0]    req_sign_i,
  input  logic [NB_REQ-1:0]    req_zero_i,
  input  logic [NB_REQ-1:0]    req_NaR_i,
  input  logic [NB_REQ*FW-1:0] req_fraction_i,
  input  logic [NB_REQ*SW-1:0] req_scale_i,
  output logic                 q_rts_o,
  input  logic                 q_rtr_i,
  output logic                 q_sow_o,
  output logic                 q_eow_o,
  output logic                 q_sign_o,
  output logic                 q_zero_o,
  output logic                 q_NaR_o,
  output logic [FW-1:0]        q_fraction_o,
  output logic [SW-1:0]        q_scale_o,
  input  logic                 qo_rts_i,
  input  logic                 qo_rtr_i,
  input  logic                 qo_eow_i,
  output logic [OW-1:0]        owner_o,
  output logic                 owner_valid_o,
  output logic                 err_len_o,
  output logic                 err_tag_o
);

  localparam logic [LOG_NB_ACCUM:0] BEAT_LIMIT = {1'b1, {LOG_NB_ACCUM{1'b0}}};

  arb_state_t            state;
  arb_state_t            state_nxt;
  logic [OW-1:0]         owner;
  logic [OW-1:0]         rr_ptr;
  logic [LOG_NB_ACCUM:0] beat_cnt;
  logic [NB_REQ-1:0]     eligible;
  logic                  sel_rts;
  logic                  sel_eow;
  logic                  block;
  logic                  xfer;
  logic                  eow_xfer;
  logic                  tag_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [OW-1:0]         fifo_head;

  // First eligible requester at or after ptr, scanning upwards with wrap.
  function automatic logic [OW-1:0] rr_pick(logic [NB_REQ-1:0] elig, logic [OW-1:0] ptr);
    logic [OW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      idx = (int'(ptr) + i) % NB_REQ;
      if (!found && elig[idx]) begin
        sel   = OW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign eligible = req_rts_i & req_sow_i;
  assign xfer     = q_rts_o & q_rtr_i;
  assign eow_xfer = xfer & sel_eow;
  assign tag_pop  = qo_rts_i & qo_rtr_i & qo_eow_i;

  // The owner's beat is muxed onto the quire side in every state; only the
  // handshake decides whether it is actually offered.
  always_comb begin
    sel_rts      = 1'b0;
    sel_eow      = 1'b0;
    q_sow_o      = 1'b0;
    q_eow_o      = 1'b0;
    q_sign_o     = 1'b0;
    q_zero_o     = 1'b0;
    q_NaR_o      = 1'b0;
    q_fraction_o = '0;
    q_scale_o    = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (OW'(k) == owner) begin
        sel_rts      = req_rts_i[k];
        sel_eow      = req_eow_i[k];
        q_sow_o      = req_sow_i[k];
        q_eow_o      = req_eow_i[k];
        q_sign_o     = req_sign_i[k];
        q_zero_o     = req_zero_i[k];
        q_NaR_o      = req_NaR_i[k];
        q_fraction_o = req_fraction_i[k*FW +: FW];
        q_scale_o    = req_scale_i[k*SW +: SW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // An eow beat is held back while the tag FIFO is full, so every finished
  // window is guaranteed a tag slot.
  always_comb begin
    state_nxt = state;
    block     = 1'b0;
    q_rts_o   = 1'b0;
    req_rtr_o = '0;
    case (state)
      ARB_IDLE: begin
        if (|eligible) state_nxt = ARB_GRANT;
      end
      ARB_GRANT: begin
        block   = sel_eow & fifo_full;
        q_rts_o = sel_rts & ~block;
        for (int k = 0; k < NB_REQ; k++) begin
          if (OW'(k) == owner) req_rtr_o[k] = q_rtr_i & ~block;
        end
        if (sel_rts & ~block & q_rtr_i & sel_eow) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Owner is latched on the arbitration decision; the pointer advances past
  // the owner once its window closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == ARB_IDLE && |eligible) owner <= rr_pick(eligible, rr_ptr);
      if (eow_xfer) rr_ptr <= (owner == OW'(NB_REQ - 1)) ? '0 : owner + 1'b1;
    end
  end

  // Beat counter saturates at the limit so every later beat keeps flagging.
  // A sow beat (including a mid-window restart) begins a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      err_len_o <= 1'b0;
      err_tag_o <= 1'b0;
    end else begin
      if (xfer) begin
        if (q_sow_o) begin
          beat_cnt <= {{LOG_NB_ACCUM{1'b0}}, 1'b1};
        end else if (beat_cnt == BEAT_LIMIT) begin
          err_len_o <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (tag_pop && fifo_empty) err_tag_o <= 1'b1;
    end
  end

  quire_window_arbiter_tag_fifo #(
    .WIDTH (OW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (eow_xfer),
    .push_data (owner),
    .pop       (tag_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign owner_valid_o = ~fifo_empty;
  assign owner_o       = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_quire_window_arbiter.sv
// tb_quire_window_arbiter
//   Table-driven bench: each record is one clock cycle of inputs plus the
//   combinational/registered outputs expected in that cycle. Requester k's
//   fraction is {k, dat}, its scale is k+1; sign/zero/NaR are fixed per
//   requester so the muxed flags identify the granted requester.
module tb_quire_window_arbiter;
  import quire_window_arbiter_pkg::*;

  localparam int NB_REQ = 4;
  localparam int FW     = get_fraction_width(8, 0, 1);
  localparam int SW     = get_scale_width(8, 0, 1);

  logic                 clk;
  logic                 rst;
  logic [NB_REQ-1:0]    req_rts_i, req_rtr_o, req_sow_i, req_eow_i;
  logic [NB_REQ-1:0]    req_sign_i, req_zero_i, req_NaR_i;
  logic [NB_REQ*FW-1:0] req_fraction_i;
  logic [NB_REQ*SW-1:0] req_scale_i;
  logic                 q_rts_o, q_rtr_i, q_sow_o, q_eow_o, q_sign_o, q_zero_o, q_NaR_o;
  logic [FW-1:0]        q_fraction_o;
  logic [SW-1:0]        q_scale_o;
  logic                 qo_rts_i, qo_rtr_i, qo_eow_i;
  logic [1:0]           owner_o;
  logic                 owner_valid_o, err_len_o, err_tag_o;

  quire_window_arbiter #(
    .POSIT_WIDTH   (8),
    .POSIT_ES      (0),
    .IS_PROD_ACCUM (1),
    .LOG_NB_ACCUM  (2),
    .NB_REQ        (NB_REQ),
    .TAG_DEPTH     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_rts_i      (req_rts_i),
    .req_rtr_o      (req_rtr_o),
    .req_sow_i      (req_sow_i),
    .req_eow_i      (req_eow_i),
    .req_sign_i     (req_sign_i),
    .req_zero_i     (req_zero_i),
    .req_NaR_i      (req_NaR_i),
    .req_fraction_i (req_fraction_i),
    .req_scale_i    (req_scale_i),
    .q_rts_o        (q_rts_o),
    .q_rtr_i        (q_rtr_i),
    .q_sow_o        (q_sow_o),
    .q_eow_o        (q_eow_o),
    .q_sign_o       (q_sign_o),
    .q_zero_o       (q_zero_o),
    .q_NaR_o        (q_NaR_o),
    .q_fraction_o   (q_fraction_o),
    .q_scale_o      (q_scale_o),
    .qo_rts_i       (qo_rts_i),
    .qo_rtr_i       (qo_rtr_i),
    .qo_eow_i       (qo_eow_i),
    .owner_o        (owner_o),
    .owner_valid_o  (owner_valid_o),
    .err_len_o      (err_len_o),
    .err_tag_o      (err_tag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] rts, sow, eow;
    bit         q_rtr, pop;
    logic [1:0] who;
    logic [7:0] dat;
    logic [3:0] e_rtr;
    bit         e_qrts, e_sow, e_eow;
    logic [11:0] e_frac;
    bit         e_ovalid;
    logic [1:0] e_owner;
    bit         e_errlen, e_errtag;
  } vec_t;

  vec_t          vecs[$];
  logic [FW-1:0] frac[NB_REQ];
  int            nVec;
  int            nMis;

  function automatic vec_t mk(bit r, logic [3:0] rts, logic [3:0] sow, logic [3:0] eow,
                              bit qr, bit pop, logic [1:0] who, logic [7:0] dat,
                              logic [3:0] ertr, bit eq, bit es, bit ee, logic [11:0] ef,
                              bit eov, logic [1:0] eown, bit eel, bit eet);
    vec_t v;
    v.rst = r; v.rts = rts; v.sow = sow; v.eow = eow; v.q_rtr = qr; v.pop = pop;
    v.who = who; v.dat = dat; v.e_rtr = ertr; v.e_qrts = eq; v.e_sow = es; v.e_eow = ee;
    v.e_frac = ef; v.e_ovalid = eov; v.e_owner = eown; v.e_errlen = eel; v.e_errtag = eet;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    req_rts_i = v.rts;
    req_sow_i = v.sow;
    req_eow_i = v.eow;
    q_rtr_i   = v.q_rtr;
    qo_rts_i  = v.pop;
    qo_rtr_i  = v.pop;
    qo_eow_i  = v.pop;
    frac[v.who] = FW'({2'b00, v.who, v.dat});
    for (int k = 0; k < NB_REQ; k++) req_fraction_i[k*FW +: FW] = frac[k];
  endtask

  task automatic checkField(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s vec %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [1:0] own;
    own = v.e_frac[9:8];
    checkField("req_rtr", idx, 32'(req_rtr_o), 32'(v.e_rtr));
    checkField("q_rts", idx, 32'(q_rts_o), 32'(v.e_qrts));
    checkField("owner_valid", idx, 32'(owner_valid_o), 32'(v.e_ovalid));
    checkField("owner", idx, 32'(owner_o), 32'(v.e_owner));
    checkField("err_len", idx, 32'(err_len_o), 32'(v.e_errlen));
    checkField("err_tag", idx, 32'(err_tag_o), 32'(v.e_errtag));
    if (v.e_qrts) begin
      checkField("q_sow", idx, 32'(q_sow_o), 32'(v.e_sow));
      checkField("q_eow", idx, 32'(q_eow_o), 32'(v.e_eow));
      checkField("q_fraction", idx, 32'(q_fraction_o), 32'(v.e_frac));
      checkField("q_scale", idx, 32'(q_scale_o), 32'(own) + 32'd1);
      checkField("q_sign", idx, 32'(q_sign_o), 32'(own[0]));
      checkField("q_zero", idx, 32'(q_zero_o), 32'(own == 2'd2));
      checkField("q_NaR", idx, 32'(q_NaR_o), 32'(own == 2'd3));
    end
  endtask

  initial begin
    nVec = 0;
    nMis = 0;
    rst = 1'b1;
    req_rts_i = '0; req_sow_i = '0; req_eow_i = '0;
    req_sign_i = 4'b1010; req_zero_i = 4'b0100; req_NaR_i = 4'b1000;
    q_rtr_i = 1'b0; qo_rts_i = 1'b0; qo_rtr_i = 1'b0; qo_eow_i = 1'b0;
    for (int k = 0; k < NB_REQ; k++) begin
      frac[k] = '0;
      req_scale_i[k*SW +: SW] = SW'(k + 1);
    end
    req_fraction_i = '0;

    // Reset state
    vecs.push_back(mk(1,0,0,0,0,0,0,8'h00, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,8'h00, 0,0,0,0,0, 0,0,0,0));
    // Requester 1, three-beat window, tag 1 then popped
    vecs.push_back(mk(0,4'b0010,4'b0010,0,1,0,1,8'h10, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,4'b0010,4'b0010,0,1,0,1,8'h10, 4'b0010,1,1,0,12'h110, 0,0,0,0));
    vecs.push_back(mk(0,4'b0010,0,0,1,0,1,8'h11, 4'b0010,1,0,0,12'h111, 0,0,0,0));
    vecs.push_back(mk(0,4'b0010,0,4'b0010,1,0,1,8'h12, 4'b0010,1,0,1,12'h112, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,1,8'h12, 0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,8'h12, 0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,1,8'h12, 0,0,0,0,0, 0,0,0,0));
    // Requesters 0 and 2 contend from rr_ptr=0; 2 must wait for 0's eow
    vecs.push_back(mk(1,0,0,0,0,0,0,8'h00, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,4'b0101,4'b0101,0,1,0,2,8'h30, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,4'b0101,4'b0101,0,1,0,0,8'h20, 4'b0001,1,1,0,12'h020, 0,0,0,0));
    vecs.push_back(mk(0,4'b0101,4'b0100,0,1,0,0,8'h21, 4'b0001,1,0,0,12'h021, 0,0,0,0));
    vecs.push_back(mk(0,4'b0101,4'b0100,4'b0001,1,0,0,8'h22, 4'b0001,1,0,1,12'h022, 0,0,0,0));
    vecs.push_back(mk(0,4'b0100,4'b0100,0,1,0,2,8'h30, 0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,4'b0100,4'b0100,4'b0100,1,0,2,8'h30, 4'b0100,1,1,1,12'h230, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,2,8'h30, 0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,2,8'h30, 0,0,0,0,0, 1,2,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,2,8'h30, 0,0,0,0,0, 0,0,0,0));
    // rr_ptr now 3: requester 3 beats requester 1
    vecs.push_back(mk(0,4'b1010,4'b1010,4'b1010,1,0,3,8'h40, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,4'b1010,4'b1010,4'b1010,1,0,3,8'h40, 4'b1000,1,1,1,12'h340, 0,0,0,0));
    vecs.push_back(mk(0,4'b0010,4'b0010,4'b0010,1,1,1,8'h41, 0,0,0,0,0, 1,3,0,0));
    vecs.push_back(mk(0,4'b0010,4'b0010,4'b0010,1,0,1,8'h41, 4'b0010,1,1,1,12'h141, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,8'h41, 0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,1,8'h41, 0,0,0,0,0, 0,0,0,0));
    // q_rtr toggling mid-window: stalled beats held stable, each delivered once
    vecs.push_back(mk(0,4'b0100,4'b0100,0,1,0,2,8'h50, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,4'b0100,4'b0100,0,1,0,2,8'h50, 4'b0100,1,1,0,12'h250, 0,0,0,0));
    vecs.push_back(mk(0,4'b0100,0,0,0,0,2,8'h51, 0,1,0,0,12'h251, 0,0,0,0));
    vecs.push_back(mk(0,4'b0100,0,0,1,0,2,8'h51, 4'b0100,1,0,0,12'h251, 0,0,0,0));
    vecs.push_back(mk(0,4'b0100,0,4'b0100,0,0,2,8'h52, 0,1,0,1,12'h252, 0,0,0,0));
    vecs.push_back(mk(0,4'b0100,0,4'b0100,1,0,2,8'h52, 4'b0100,1,0,1,12'h252, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,2,8'h52, 0,0,0,0,0, 1,2,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,2,8'h52, 0,0,0,0,0, 0,0,0,0));
    // Four single-beat windows fill the tag FIFO
    for (int n = 0; n < 4; n++) begin
      vecs.push_back(mk(0,4'b0001,4'b0001,4'b0001,1,0,0,8'(8'h60 + n), 0,0,0,0,0, n > 0,0,0,0));
      vecs.push_back(mk(0,4'b0001,4'b0001,4'b0001,1,0,0,8'(8'h60 + n),
                        4'b0001,1,1,1,{4'h0, 8'(8'h60 + n)}, n > 0,0,0,0));
    end
    // Fifth eow is held until one tag is popped
    vecs.push_back(mk(0,4'b0001,4'b0001,4'b0001,1,0,0,8'h64, 0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,4'b0001,4'b0001,4'b0001,1,0,0,8'h64, 0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,4'b0001,4'b0001,4'b0001,1,0,0,8'h64, 0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,4'b0001,4'b0001,4'b0001,1,1,0,8'h64, 0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,4'b0001,4'b0001,4'b0001,1,0,0,8'h64, 4'b0001,1,1,1,12'h064, 1,0,0,0));
    for (int n = 0; n < 4; n++)
      vecs.push_back(mk(0,0,0,0,1,1,0,8'h64, 0,0,0,0,0, 1,0,0,0));
    // Pop on an empty FIFO raises the sticky tag error
    vecs.push_back(mk(0,0,0,0,1,1,0,8'h64, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,8'h64, 0,0,0,0,0, 0,0,0,1));
    // Reset clears the errors; a 5-beat window exceeds 2^2 beats
    vecs.push_back(mk(1,0,0,0,0,0,0,8'h00, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,4'b1000,4'b1000,0,1,0,3,8'h70, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,4'b1000,4'b1000,0,1,0,3,8'h70, 4'b1000,1,1,0,12'h370, 0,0,0,0));
    vecs.push_back(mk(0,4'b1000,0,0,1,0,3,8'h71, 4'b1000,1,0,0,12'h371, 0,0,0,0));
    vecs.push_back(mk(0,4'b1000,0,0,1,0,3,8'h72, 4'b1000,1,0,0,12'h372, 0,0,0,0));
    vecs.push_back(mk(0,4'b1000,0,0,1,0,3,8'h73, 4'b1000,1,0,0,12'h373, 0,0,0,0));
    vecs.push_back(mk(0,4'b1000,0,4'b1000,1,0,3,8'h74, 4'b1000,1,0,1,12'h374, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,3,8'h74, 0,0,0,0,0, 1,3,1,0));
    vecs.push_back(mk(0,0,0,0,1,1,3,8'h74, 0,0,0,0,0, 1,3,1,0));
    vecs.push_back(mk(0,0,0,0,1,0,3,8'h74, 0,0,0,0,0, 0,0,1,0));
    // One tag queued, then reset during beat 2 of requester 1's window
    vecs.push_back(mk(0,4'b0100,4'b0100,4'b0100,1,0,2,8'h90, 0,0,0,0,0, 0,0,1,0));
    vecs.push_back(mk(0,4'b0100,4'b0100,4'b0100,1,0,2,8'h90, 4'b0100,1,1,1,12'h290, 0,0,1,0));
    vecs.push_back(mk(0,4'b0010,4'b0010,0,1,0,1,8'h80, 0,0,0,0,0, 1,2,1,0));
    vecs.push_back(mk(0,4'b0010,4'b0010,0,1,0,1,8'h80, 4'b0010,1,1,0,12'h180, 1,2,1,0));
    vecs.push_back(mk(1,4'b0010,0,0,1,0,1,8'h81, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,4'b0010,4'b0010,4'b0010,1,0,1,8'h82, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,4'b0010,4'b0010,4'b0010,1,0,1,8'h82, 4'b0010,1,1,1,12'h182, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,8'h82, 0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,1,8'h82, 0,0,0,0,0, 0,0,0,0));

    $display("[TB] applying %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
      nVec++;
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
